matmul_tile_sequencer: RTL and testbench

Address and control sequencer for the tiled matrix-multiplication datapath. It computes C = A x B, where A is ROWS x INNER and B is INNER x COLS, both held in slice-packed memories (one word = N elements). It walks a three-level loop nest (A row-slice, B column-slice, inner index) under a start/done command handshake and a valid/ready read handshake. It emits per-beat read addresses plus accumulator clear/last markers and tile indices to the N x N processing array. It generalises the fixed square-matrix counter pair to rectangular shapes with backpressure.

---
 rtl/matmul_tile_sequencer.sv | 175 +++++++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer
// Address/control sequencer for a tiled C = A x B datapath. A (ROWS x INNER)
// and B (INNER x COLS) sit in slice-packed memories, one word = N elements.
// The loop nest is i (A row-slice), j (B column-slice), k (inner index), with k
// innermost. Each beat carries the A/B word addresses, accumulator markers and
// the tile indices of the tile being built.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      command pulse, accepted only in IDLE
//   busy       high while a command is running
//   done       one-cycle pulse after the last beat is accepted
//   rd_valid   address beat valid
//   rd_ready   downstream accepts the beat
//   rd_addr_A  A word address = i*INNER + k
//   rd_addr_B  B word address = j*INNER + k
//   acc_clr    beat is k == 0
//   acc_last   beat is k == INNER-1
//   tile_row   current i
//   tile_col   current j
//   state_dbg  FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Handshake: a beat transfers on a rising edge where rd_valid && rd_ready.
// Once rd_valid is high, the beat (addresses, markers, tile indices) stays
// unchanged until it transfers; rd_valid never drops without a transfer,
// except on reset.
module matmul_tile_sequencer #(
    parameter int N     = 3,
    parameter int ROWS  = 6,
    parameter int INNER = 6,
    parameter int COLS  = 6,
    localparam int RS = ROWS / N,
    localparam int CS = COLS / N,
    localparam int AW = (RS * INNER > 1) ? $clog2(RS * INNER) : 1,
    localparam int BW = (CS * INNER > 1) ? $clog2(CS * INNER) : 1,
    localparam int IW = (RS > 1) ? $clog2(RS) : 1,
    localparam int JW = (CS > 1) ? $clog2(CS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr_A,
    output logic [BW-1:0] rd_addr_B,
    output logic          acc_clr,
    output logic          acc_last,
    output logic [IW-1:0] tile_row,
    output logic [JW-1:0] tile_col,
    output logic [1:0]    state_dbg
);

    localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(INNER - 1);
    localparam logic [IW-1:0] I_LAST = IW'(RS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(CS - 1);
    localparam logic [AW-1:0] A_STEP = AW'(INNER);
    localparam logic [BW-1:0] B_STEP = BW'(INNER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [AW-1:0] base_a;
    logic [BW-1:0] base_b;

    logic          k_last, j_last, i_last, end_of_cmd;
    logic [KW-1:0] k_nxt;
    logic [IW-1:0] i_nxt;
    logic [JW-1:0] j_nxt;
    logic [AW-1:0] base_a_nxt;
    logic [BW-1:0] base_b_nxt;

    assign state_dbg = state;

    // Counter values after the current beat transfers. tile_row/tile_col
    // double as the i/j counters; the bases replace i*INNER and j*INNER so
    // the address path is a single adder.
    always_comb begin
        k_last     = (k == K_LAST);
        j_last     = (tile_col == J_LAST);
        i_last     = (tile_row == I_LAST);
        end_of_cmd = k_last && j_last && i_last;
        k_nxt      = k_last ? '0 : k + KW'(1);
        j_nxt      = tile_col;
        i_nxt      = tile_row;
        base_a_nxt = base_a;
        base_b_nxt = base_b;
        if (k_last) begin
            if (j_last) begin
                j_nxt      = '0;
                base_b_nxt = '0;
                i_nxt      = tile_row + IW'(1);
                base_a_nxt = base_a + A_STEP;
            end else begin
                j_nxt      = tile_col + JW'(1);
                base_b_nxt = base_b + B_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k         <= '0;
            base_a    <= '0;
            base_b    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr_A <= '0;
            rd_addr_B <= '0;
            acc_clr   <= 1'b0;
            acc_last  <= 1'b0;
            tile_row  <= '0;
            tile_col  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        rd_valid  <= 1'b1;
                        k         <= '0;
                        base_a    <= '0;
                        base_b    <= '0;
                        tile_row  <= '0;
                        tile_col  <= '0;
                        rd_addr_A <= '0;
                        rd_addr_B <= '0;
                        acc_clr   <= 1'b1;
                        acc_last  <= (INNER == 1);
                    end
                end
                S_RUN: begin
                    if (rd_ready) begin
                        if (end_of_cmd) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            rd_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            k         <= k_nxt;
                            base_a    <= base_a_nxt;
                            base_b    <= base_b_nxt;
                            tile_row  <= i_nxt;
                            tile_col  <= j_nxt;
                            rd_addr_A <= base_a_nxt + AW'(k_nxt);
                            rd_addr_B <= base_b_nxt + BW'(k_nxt);
                            acc_clr   <= (k_nxt == '0);
                            acc_last  <= (k_nxt == K_LAST);
                        end
                    end
                end
                S_DONE: begin
                    // start seen here is dropped, not remembered
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb_matmul_tile_sequencer
// Three sequencer instances: default 6x6x6 (N=3), rectangular N=2 4x3x6, and
// degenerate N=1 INNER=1 2x2. Expected beat streams come from plain nested
// loops over (i, j, k); a scenario table selects instance, rd_ready duty and
// start poking, and hand-written sequences cover reset and abort.
module tb_matmul_tile_sequencer;

  localparam int BEAT_W = 34;

  typedef struct packed {
    logic              valid;
    logic              busy;
    logic              done;
    logic [BEAT_W-1:0] beat;  // {clr, last, row, col, addr_a, addr_b}
  } obs_t;

  typedef struct {
    int sel;
    int ready_pct;
    bit poke;
    int exp_beats;
    int exp_max_a;
    int exp_max_b;
  } vec_t;

  int cfg_n[3]     = '{3, 2, 1};
  int cfg_rows[3]  = '{6, 4, 2};
  int cfg_inner[3] = '{6, 3, 1};
  int cfg_cols[3]  = '{6, 6, 2};

  logic clk;
  logic rst;
  logic start_v[3];
  logic ready_v[3];

  logic v0, bz0, d0, cl0, ls0;
  logic [3:0] a0, b0;
  logic [0:0] r0, c0;
  logic [1:0] s0;

  logic v1, bz1, d1, cl1, ls1;
  logic [2:0] a1;
  logic [3:0] b1;
  logic [0:0] r1;
  logic [1:0] c1;
  logic [1:0] s1;

  logic v2, bz2, d2, cl2, ls2;
  logic [0:0] a2, b2, r2, c2;
  logic [1:0] s2;

  logic [BEAT_W-1:0] exp_q[$];
  int n_vec;
  int n_err;
  vec_t vecs[7];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  matmul_tile_sequencer #(.N(3), .ROWS(6), .INNER(6), .COLS(6)) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(bz0), .done(d0),
    .rd_valid(v0), .rd_ready(ready_v[0]), .rd_addr_A(a0), .rd_addr_B(b0),
    .acc_clr(cl0), .acc_last(ls0), .tile_row(r0), .tile_col(c0), .state_dbg(s0)
  );

  matmul_tile_sequencer #(.N(2), .ROWS(4), .INNER(3), .COLS(6)) u_rect (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(bz1), .done(d1),
    .rd_valid(v1), .rd_ready(ready_v[1]), .rd_addr_A(a1), .rd_addr_B(b1),
    .acc_clr(cl1), .acc_last(ls1), .tile_row(r1), .tile_col(c1), .state_dbg(s1)
  );

  matmul_tile_sequencer #(.N(1), .ROWS(2), .INNER(1), .COLS(2)) u_deg (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(bz2), .done(d2),
    .rd_valid(v2), .rd_ready(ready_v[2]), .rd_addr_A(a2), .rd_addr_B(b2),
    .acc_clr(cl2), .acc_last(ls2), .tile_row(r2), .tile_col(c2), .state_dbg(s2)
  );

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    case (sel)
      0: o = {v0, bz0, d0, cl0, ls0, 8'(r0), 8'(c0), 8'(a0), 8'(b0)};
      1: o = {v1, bz1, d1, cl1, ls1, 8'(r1), 8'(c1), 8'(a1), 8'(b1)};
      default: o = {v2, bz2, d2, cl2, ls2, 8'(r2), 8'(c2), 8'(a2), 8'(b2)};
    endcase
    return o;
  endfunction

  function automatic logic [1:0] get_state(input int sel);
    case (sel)
      0: return s0;
      1: return s1;
      default: return s2;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference beat stream: C tiles in row-major tile order, k innermost.
  task automatic build_expected(input int sel);
    int rs, cs, inner;
    rs    = cfg_rows[sel] / cfg_n[sel];
    cs    = cfg_cols[sel] / cfg_n[sel];
    inner = cfg_inner[sel];
    exp_q.delete();
    for (int i = 0; i < rs; i++)
      for (int j = 0; j < cs; j++)
        for (int k = 0; k < inner; k++)
          exp_q.push_back({(k == 0), (k == inner - 1), 8'(i), 8'(j),
                           8'(i * inner + k), 8'(j * inner + k)});
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input int sel, input int pct, input bit poke,
                         input int exp_beats, input int exp_max_a, input int exp_max_b);
    obs_t o, prev;
    bit prev_stall, got_done;
    int cycles, stalls, beats, max_a, max_b, guard;
    logic [BEAT_W-1:0] want;
    build_expected(sel);
    guard = 0;
    o = get_obs(sel);
    while ((o.busy || o.done) && guard < 200) begin
      @(negedge clk);
      o = get_obs(sel);
      guard++;
    end
    start_v[sel] = 1'b1;
    ready_v[sel] = 1'b0;
    @(negedge clk);
    start_v[sel] = 1'b0;
    cycles = 0; stalls = 0; beats = 0; max_a = 0; max_b = 0;
    prev_stall = 1'b0; got_done = 1'b0;
    prev = '0;
    while (!got_done && cycles < 2000) begin
      o = get_obs(sel);
      cycles++;
      if (o.done) begin
        got_done = 1'b1;
        check("done_cycle_flags", {o.valid, o.busy}, 2'b00);
        if (poke) start_v[sel] = 1'b1;
      end else begin
        check("run_flags", {o.valid, o.busy, o.done}, 3'b110);
        if (prev_stall) check("stall_hold", o.beat, prev.beat);
        ready_v[sel] = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
        if (poke) start_v[sel] = ($urandom_range(3) == 0);
        if (o.valid && ready_v[sel]) begin
          beats++;
          if (int'(o.beat[15:8]) > max_a) max_a = int'(o.beat[15:8]);
          if (int'(o.beat[7:0]) > max_b) max_b = int'(o.beat[7:0]);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_beat: got beat %0h expected none", o.beat);
          end else begin
            want = exp_q.pop_front();
            check("beat", o.beat, want);
          end
          prev_stall = 1'b0;
        end else begin
          stalls++;
          prev_stall = 1'b1;
        end
        prev = o;
      end
      @(negedge clk);
    end
    start_v[sel] = 1'b0;
    o = get_obs(sel);
    check("done_seen", got_done, 1);
    check("done_single", {o.done, o.busy, o.valid}, 3'b000);
    check("state_idle", get_state(sel), 2'd0);
    check("beats_left", exp_q.size(), 0);
    check("beat_count", beats, exp_beats);
    check("cycle_count", cycles, exp_beats + stalls + 1);
    check("max_addr_a", max_a, exp_max_a);
    check("max_addr_b", max_b, exp_max_b);
    @(negedge clk);
    o = get_obs(sel);
    check("no_restart", {o.done, o.busy, o.valid}, 3'b000);
  endtask

  // ---------------- main ----------------
  initial begin
    obs_t o;
    logic [BEAT_W-1:0] want;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      start_v[s] = 1'b0;
      ready_v[s] = 1'b0;
    end
    vecs[0] = '{0, 100, 1'b0, 24, 11, 11};
    vecs[1] = '{1, 100, 1'b0, 18, 5, 8};
    vecs[2] = '{2, 100, 1'b0, 4, 1, 1};
    vecs[3] = '{0, 50, 1'b0, 24, 11, 11};
    vecs[4] = '{1, 50, 1'b0, 18, 5, 8};
    vecs[5] = '{2, 50, 1'b0, 4, 1, 1};
    vecs[6] = '{0, 50, 1'b1, 24, 11, 11};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset_outputs", get_obs(s), '0);
      check("reset_state", get_state(s), 2'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    o = get_obs(0);
    check("idle_after_release", {o.valid, o.busy, o.done}, 3'b000);

    for (int t = 0; t < 7; t++)
      run_cmd(vecs[t].sel, vecs[t].ready_pct, vecs[t].poke,
              vecs[t].exp_beats, vecs[t].exp_max_a, vecs[t].exp_max_b);

    // Abort at beat 10 of the default shape, then replay from scratch.
    build_expected(0);
    for (int b = 0; b < 10; b++) void'(exp_q.pop_front());
    want = exp_q[0];
    start_v[0] = 1'b1;
    ready_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    o = get_obs(0);
    check("beat10_before_abort", o.beat, want);
    rst = 1'b0;
    #1;
    check("abort_outputs", get_obs(0), '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = get_obs(0);
      check("abort_no_done", {o.done, o.busy, o.valid}, 3'b000);
    end
    rst = 1'b1;
    @(negedge clk);
    o = get_obs(0);
    check("abort_released_idle", {o.done, o.busy, o.valid}, 3'b000);
    run_cmd(0, 100, 1'b0, 24, 11, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
